spi_input_receiver: RTL and testbench

//  Slave-side SPI receive front end, directly upstream of SPI_output_controller.
//  - Synchronises the external SCK/SS/MOSI pins into the clk domain and deserialises MOSI LSB-first.
//  - Emits each completed byte on SPI_in with a one-cycle shift_SPI strobe; this is the strobe
//    SPI_output_controller uses to load its next MISO byte.
//  - Tracks frame boundaries (SS low to SS high) and counts bytes for the network input loader.

---
 rtl/spi_input_receiver.sv | 173 +++++++++++++++++
 tb/tb_spi_input_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_input_receiver.sv
// SPI mode-0 slave receive front end: synchronise SCK/SS/MOSI, deserialise LSB-first.
// Optional SCK glitch filter: define SPI_RX_GLITCH_FILTER_EN.
module spi_input_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int BYTE_CNT_W  = 10
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  SCK,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic                  shift_SPI,
    output logic [7:0]            SPI_in,
    output logic [BYTE_CNT_W-1:0] byte_count,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic                  frame_error
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;

    logic sck_s, ss_s, mosi_s, ss_valid;
    logic sck_e, mosi_e;
    logic sck_prev_q, sck_prev_d;
    logic sck_rise;

    state_t                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            sr_q, sr_d;
    logic [7:0]            spi_in_q, spi_in_d;
    logic [BYTE_CNT_W-1:0] byte_count_q, byte_count_d;
    logic                  shift_q, shift_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    // ss_s only counts once real pin samples have replaced the reset idle value
    assign ss_valid = fill_q[SYNC_STAGES-1];

`ifdef SPI_RX_GLITCH_FILTER_EN
    logic sck_flt_q, sck_flt_d;
    logic mosi_dly_q, mosi_dly_d;

    always_comb begin
        sck_flt_d  = sck_flt_q;
        mosi_dly_d = mosi_s;
        if (sck_sync_q[SYNC_STAGES-1] == sck_sync_q[SYNC_STAGES-2]) begin
            sck_flt_d = sck_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_flt_q  <= 1'b0;
            mosi_dly_q <= 1'b0;
        end else begin
            sck_flt_q  <= sck_flt_d;
            mosi_dly_q <= mosi_dly_d;
        end
    end

    assign sck_e  = sck_flt_q;
    assign mosi_e = mosi_dly_q;
`else
    assign sck_e  = sck_s;
    assign mosi_e = mosi_s;
`endif

    assign sck_prev_d = sck_e;
    assign sck_rise   = sck_e & ~sck_prev_q;

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q | (ss_s & ss_valid);
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        spi_in_d     = spi_in_q;
        byte_count_d = byte_count_q;
        shift_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!ss_s && armed_q) begin
                    state_d      = ACTIVE;
                    bit_cnt_d    = 3'd0;
                    sr_d         = 8'h00;
                    byte_count_d = '0;
                end
            end
            ACTIVE: begin
                // SS deassertion wins over a coincident SCK edge
                if (ss_s) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    err_d     = (bit_cnt_q != 3'd0);
                    bit_cnt_d = 3'd0;
                end else if (sck_rise) begin
                    sr_d      = {mosi_e, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        spi_in_d = {mosi_e, sr_q[7:1]};
                        shift_d  = 1'b1;
                        if (byte_count_q != '1) begin
                            byte_count_d = byte_count_q + BYTE_CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_sync_q   <= '0;
            ss_sync_q    <= '1;
            mosi_sync_q  <= '0;
            fill_q       <= '0;
            sck_prev_q   <= 1'b0;
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 3'd0;
            sr_q         <= 8'h00;
            spi_in_q     <= 8'h00;
            byte_count_q <= '0;
            shift_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sck_sync_q   <= sck_sync_d;
            ss_sync_q    <= ss_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            fill_q       <= fill_d;
            sck_prev_q   <= sck_prev_d;
            state_q      <= state_d;
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            spi_in_q     <= spi_in_d;
            byte_count_q <= byte_count_d;
            shift_q      <= shift_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign shift_SPI    = shift_q;
    assign SPI_in       = spi_in_q;
    assign byte_count   = byte_count_q;
    assign frame_active = (state_q == ACTIVE);
    assign frame_done   = done_q;
    assign frame_error  = err_q;

endmodule

// File: tb/tb_spi_input_receiver.sv
// Scoreboard bench for spi_input_receiver: bytes queued when driven, checked on shift_SPI.
`timescale 1ns/1ps
module tb_spi_input_receiver;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          SCK = 1'b0;
    logic          SS = 1'b1;
    logic          MOSI = 1'b0;
    logic          shift_SPI;
    logic [7:0]    SPI_in;
    logic [CW-1:0] byte_count;
    logic          frame_active;
    logic          frame_done;
    logic          frame_error;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   total = 0;
    int   bad = 0;
    int   n_shift = 0, n_done = 0, n_err = 0, n_both = 0;
    int   s_sh, s_dn, s_er, s_bo;
    int   fcnt = 0;

    spi_input_receiver #(
        .SYNC_STAGES(2),
        .BYTE_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .SCK         (SCK),
        .SS          (SS),
        .MOSI        (MOSI),
        .shift_SPI   (shift_SPI),
        .SPI_in      (SPI_in),
        .byte_count  (byte_count),
        .frame_active(frame_active),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #2.5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (shift_SPI) begin
            n_shift++;
            if (sb.size() == 0) begin
                chk("sb_has_entry", sb.size(), 1);
            end else begin
                e_m = sb.pop_front();
                chk("spi_in", SPI_in, e_m.d);
                chk("byte_count", byte_count, e_m.c);
            end
        end
        if (frame_done) n_done++;
        if (frame_error) n_err++;
        if (frame_done && frame_error) n_both++;
    end

    task automatic snap();
        s_sh = n_shift;
        s_dn = n_done;
        s_er = n_err;
        s_bo = n_both;
    endtask

    task automatic send_bit(input logic b);
        MOSI = b;
        #20;
        SCK = 1'b1;
        #41;
        SCK = 1'b0;
        #21;
    endtask

    task automatic send_byte(input logic [7:0] d);
        fcnt++;
        sb.push_back('{d, (fcnt > CMAX) ? CMAX : fcnt});
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic frame_start();
        SS = 1'b0;
        fcnt = 0;
        #60;
    endtask

    task automatic frame_end();
        #40;
        SS = 1'b1;
        #60;
    endtask

    task automatic glitch();
        @(negedge clk);
        SCK = 1'b1;
        @(negedge clk);
        SCK = 1'b0;
        #40;
    endtask

    initial begin
        logic [7:0] sat_bytes [5];
        sat_bytes = '{8'h3C, 8'hC3, 8'h5A, 8'h00, 8'h81};
        #1;
        n_rst = 1'b0;
        SS = 1'b1;
        #20;
        chk("rst_shift", shift_SPI, 0);
        chk("rst_spi_in", SPI_in, 0);
        chk("rst_count", byte_count, 0);
        chk("rst_active", frame_active, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_error", frame_error, 0);
        n_rst = 1'b1;
        #50;
        chk("idle_active", frame_active, 0);

        snap();
        frame_start();
        chk("t2_active", frame_active, 1);
        send_byte(8'h85);
        frame_end();
        chk("t2_shifts", n_shift - s_sh, 1);
        chk("t2_done", n_done - s_dn, 1);
        chk("t2_err", n_err - s_er, 0);
        chk("t2_count", byte_count, 1);
        chk("t2_inactive", frame_active, 0);

        snap();
        frame_start();
        send_byte(8'hFF);
        send_byte(8'h01);
        frame_end();
        chk("t3_shifts", n_shift - s_sh, 2);
        chk("t3_count", byte_count, 2);
        chk("t3_err", n_err - s_er, 0);

        snap();
        frame_start();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        frame_end();
        chk("t4_shifts", n_shift - s_sh, 0);
        chk("t4_err", n_err - s_er, 1);
        chk("t4_both", n_both - s_bo, 1);
        chk("t4_spi_in", SPI_in, 8'h01);

        snap();
        SS = 1'b0;
        #60;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        n_rst = 1'b0;
        #13;
        chk("t5_async_clr", SPI_in, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #60;
        chk("t5_no_shift", n_shift - s_sh, 0);
        chk("t5_not_active", frame_active, 0);
        chk("t5_count", byte_count, 0);
        SS = 1'b1;
        #60;
        chk("t5_no_done", n_done - s_dn, 0);
        frame_start();
        send_byte(8'h07);
        frame_end();
        chk("t5_shifts", n_shift - s_sh, 1);
        chk("t5_spi_in", SPI_in, 8'h07);

        snap();
        frame_start();
        foreach (sat_bytes[i]) send_byte(sat_bytes[i]);
        frame_end();
        chk("sat_shifts", n_shift - s_sh, 5);
        chk("sat_count", byte_count, CMAX);

        snap();
        frame_start();
        send_byte(8'h9C);
        #40;
        SS = 1'b1;
        #15;
        SS = 1'b0;
        fcnt = 0;
        #60;
        send_byte(8'h42);
        frame_end();
        chk("reassert_shifts", n_shift - s_sh, 2);
        chk("reassert_done", n_done - s_dn, 2);
        chk("reassert_err", n_err - s_er, 0);
        chk("reassert_count", byte_count, 1);

`ifdef SPI_RX_GLITCH_FILTER_EN
        snap();
        glitch();
        frame_start();
        glitch();
        send_byte(8'hA5);
        frame_end();
        chk("glitch_shifts", n_shift - s_sh, 1);
        chk("glitch_err", n_err - s_er, 0);
        chk("glitch_spi_in", SPI_in, 8'hA5);
`endif

        #200;
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
